// File: rtl/exe_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, and an iterative
// 1-bit/cycle multiply/unsigned-divide unit that freezes upstream stages while busy.
module exe_stage #(
  parameter int DATA_W = 32,
  parameter int MDU_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        exe_cmd,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [DATA_W-1:0] reg2,
  input  logic [31:0]       pc,
  input  logic              br_taken_in,
  input  logic [4:0]        dest_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [1:0]        sel_val1,
  input  logic [1:0]        sel_val2,
  input  logic [1:0]        sel_st,
  input  logic [DATA_W-1:0] mem_fw,
  input  logic [DATA_W-1:0] wb_fw,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] st_val,
  output logic [31:0]       br_addr,
  output logic              br_taken,
  output logic [4:0]        dest,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} mdu_state_t;

  mdu_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc, opa, opb;
  logic              is_div;

  logic [DATA_W-1:0] a, b, alu_comb, mdu_res;
  logic [DATA_W-1:0] acc_nxt, opa_nxt, opb_nxt;
  logic [DATA_W:0]   rem_sh;
  logic              mdu_op;

  function automatic logic [DATA_W-1:0] fwd(input logic [1:0] sel,
                                            input logic [DATA_W-1:0] base,
                                            input logic [DATA_W-1:0] mfw,
                                            input logic [DATA_W-1:0] wfw);
    case (sel)
      2'b01:   return mfw;
      2'b10:   return wfw;
      default: return base;
    endcase
  endfunction

  assign a      = fwd(sel_val1, val1, mem_fw, wb_fw);
  assign b      = fwd(sel_val2, val2, mem_fw, wb_fw);
  assign st_val = fwd(sel_st, reg2, mem_fw, wb_fw);
  assign br_addr = pc + {val2[29:0], 2'b00};
  assign dest    = dest_in;

  assign mdu_op = (MDU_EN != 0) && (exe_cmd == 4'b1100 || exe_cmd == 4'b1101);

  always_comb begin
    alu_comb = '0;
    case (exe_cmd)
      4'b0000:         alu_comb = a + b;
      4'b0010:         alu_comb = a - b;
      4'b0100:         alu_comb = a & b;
      4'b0101:         alu_comb = a | b;
      4'b0110:         alu_comb = ~(a | b);
      4'b0111:         alu_comb = a ^ b;
      4'b1000, 4'b1001: alu_comb = a << b[4:0];
      4'b1010:         alu_comb = $signed(a) >>> b[4:0];
      4'b1011:         alu_comb = a >> b[4:0];
      default:         alu_comb = '0;
    endcase
  end

  // One MDU iteration. Divide is restoring: opa holds the dividend shifting
  // out its MSB and the quotient shifting in; acc holds the remainder.
  always_comb begin
    rem_sh  = {acc, opa[DATA_W-1]};
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    if (is_div) begin
      if (rem_sh >= {1'b0, opb}) begin
        acc_nxt = rem_sh[DATA_W-1:0] - opb;
        opa_nxt = {opa[DATA_W-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[DATA_W-1:0];
        opa_nxt = {opa[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_nxt = acc + (opb[0] ? opa : '0);
      opa_nxt = opa << 1;
      opb_nxt = opb >> 1;
    end
  end

  assign mdu_res = is_div ? opa : acc;
  assign alu_res = (state == DONE) ? mdu_res : alu_comb;
  assign busy    = rst && ((state == RUN) || (state == IDLE && mdu_op));

  assign br_taken = br_taken_in && !busy;
  assign wb_en    = wb_en_in    && !busy;
  assign mem_r_en = mem_r_en_in && !busy;
  assign mem_w_en = mem_w_en_in && !busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mdu_op) begin
          opa    <= a;
          opb    <= b;
          acc    <= '0;
          cnt    <= '0;
          is_div <= exe_cmd[0];
          state  <= RUN;
        end
        RUN: begin
          acc <= acc_nxt;
          opa <= opa_nxt;
          opb <= opb_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
